writeback_stage: RTL
====================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage that sits directly upstream of the 16x16 register file write port.
//  - Accepts retiring results from execute: ALU results, or loads that wait on a memory response.
//  - Drives the register file write port (WE / WriteReg / WriteData) one register per cycle.
//  - Exports the pending destination and data so decode can forward or stall.
// PARAMETERS
//  DW          16   data width; matches register file entry width
//  AW          4    register index width (16 registers)
//  MEM_TIMEOUT 15   max cycles waiting for mem_rvalid before abandoning a load (1..255)
//  PROTECT_R0  0    1 = suppress any write whose destination is register 0
// PORTS
//  clk          in   1   rising-edge clock, shared with the register file
//  rst_n        in   1   asynchronous active-low reset
//  ex_valid     in   1   execute presents a retiring instruction
//  ex_ready     out  1   stage can accept; transfer when ex_valid && ex_ready
//  ex_we        in   1   instruction writes a register
//  ex_is_load   in   1   result comes from memory, not ex_result
//  ex_dest      in   AW  destination register index
//  ex_result    in   DW  ALU result (ignored when ex_is_load)
//  mem_rvalid   in   1   load data valid (single-cycle pulse)
//  mem_rdata    in   DW  load data
//  rf_we        out  1   register file WE
//  rf_wreg      out  AW  register file WriteReg
//  rf_wdata     out  DW  register file WriteData
//  hz_valid     out  1   a write to hz_reg is staged or outstanding
//  hz_reg       out  AW  pending destination
//  hz_data_ok   out  1   hz_data is final (forwardable); 0 = decode must stall
//  hz_data      out  DW  pending write data
//  err_timeout  out  1   sticky: a load was abandoned on timeout
//  retire_cnt   out  16  count of accepted instructions, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE; ex_ready rises on the first clock after rst_n deasserts.
//  Mid-operation reset drops any staged or outstanding write; no rf_we is issued.
//  States: IDLE, WRITE, WAIT_MEM.
//  ex_ready = 1 in IDLE and WRITE, 0 in WAIT_MEM.
//  Accept (any state with ex_ready=1):
//   - retire_cnt += 1.
//   - ex_we=0: no write; next state IDLE.
//   - ex_we=1 && !ex_is_load: latch dest and result; next state WRITE.
//   - ex_we=1 && ex_is_load: latch dest, clear timer; next state WAIT_MEM.
//   - ex_is_load with ex_we=0: treated as no write; no memory wait.
//  WRITE (exactly 1 cycle):
//   - rf_we=1, rf_wreg/rf_wdata = latched values.
//   - Back-to-back accept in the same cycle is legal, giving one rf_we per cycle.
//   - ALU latency: accept edge -> rf_we high for the following cycle (1 cycle).
//   - With no new accept, next state IDLE.
//  WAIT_MEM:
//   - Timer increments each cycle.
//   - mem_rvalid=1: latch mem_rdata; next state WRITE.
//   - Load latency = mem response cycle + 1.
//   - Timer reaches MEM_TIMEOUT without rvalid: err_timeout<=1 (sticky until reset); no write; next state IDLE.
//   - rvalid arriving on the timeout cycle wins: write happens, no error.
//  mem_rvalid outside WAIT_MEM is ignored.
//  PROTECT_R0=1 with dest 0: rf_we held 0 in WRITE; timing otherwise unchanged.
//  Hazard outputs:
//   - hz_valid=1 in WRITE and WAIT_MEM.
//   - hz_data_ok=1 only in WRITE.
//   - hz_reg/hz_data mirror the latched values.
//   - In IDLE all hz_* are 0.
//  rf_wreg/rf_wdata hold their last values when rf_we=0; the register file must qualify them with WE.
// TESTING
//  1. Reset, ALU ex_dest=3, ex_result=0x1234 -> next cycle rf_we=1, rf_wreg=3, rf_wdata=0x1234; retire_cnt=1.
//  2. Four back-to-back ALU writes R1..R4 -> rf_we high 4 consecutive cycles, ex_ready never drops.
//  3. Load to R5, mem_rvalid+0xBEEF 3 cycles later -> ex_ready=0 and hz_data_ok=0 while waiting;
//     then rf_we=1, R5=0xBEEF; then ex_ready=1.
//  4. Load to R6, no rvalid for MEM_TIMEOUT cycles -> err_timeout=1, no rf_we;
//     a later rvalid is ignored; err stays 1 until rst_n.
//  5. PROTECT_R0=1, ALU write to R0 -> rf_we stays 0; retire_cnt still increments.
//  6. Assert rst_n=0 during WAIT_MEM -> all outputs 0 immediately; no write after release;
//     retire_cnt 0xFFFF + 1 accept -> 0x0000.

Source files
------------

// File: rtl/writeback_stage.sv
// Last pipeline stage in front of the register file write port.
// It retires ALU results and memory loads one per cycle, and reports the pending write so decode can forward or stall.
module writeback_stage #(
  parameter int DW          = 16,
  parameter int AW          = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int PROTECT_R0  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic          ex_we,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_dest,
  input  logic [DW-1:0] ex_result,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          rf_we,
  output logic [AW-1:0] rf_wreg,
  output logic [DW-1:0] rf_wdata,
  output logic          hz_valid,
  output logic [AW-1:0] hz_reg,
  output logic          hz_data_ok,
  output logic [DW-1:0] hz_data,
  output logic          err_timeout,
  output logic [15:0]   retire_cnt
);

  // Handshake: a transfer from execute happens on a rising edge where ex_valid && ex_ready.
  // ex_ready depends only on registered state, never on ex_valid.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WAIT_MEM = 2'd2
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(MEM_TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic          live;
  logic [AW-1:0] dest_q;
  logic [DW-1:0] data_q;
  logic [7:0]    timer;
  logic          accept;
  logic          timeout_hit;

  // live keeps ex_ready low until the first clock after reset is released
  assign ex_ready    = live && (state != WAIT_MEM);
  assign accept      = ex_valid && ex_ready;
  assign timeout_hit = (state == WAIT_MEM) && !mem_rvalid && (timer == TIMER_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, WRITE: begin
        state_nxt = IDLE;
        if (accept && ex_we) begin
          state_nxt = ex_is_load ? WAIT_MEM : WRITE;
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          state_nxt = WRITE;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      live        <= 1'b0;
      dest_q      <= '0;
      data_q      <= '0;
      timer       <= '0;
      err_timeout <= 1'b0;
      retire_cnt  <= '0;
    end else begin
      live  <= 1'b1;
      state <= state_nxt;
      if (accept) begin
        retire_cnt <= retire_cnt + 16'd1;
        if (ex_we) begin
          dest_q <= ex_dest;
          timer  <= '0;
          if (!ex_is_load) begin
            data_q <= ex_result;
          end
        end
      end
      if (state == WAIT_MEM) begin
        timer <= timer + 8'd1;
        if (mem_rvalid) begin
          data_q <= mem_rdata;
        end
      end
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
    end
  end

  // Destination 0 can be made read-only; the WRITE cycle still takes place
  always_comb begin
    rf_we      = (state == WRITE) && !((PROTECT_R0 != 0) && (dest_q == '0));
    rf_wreg    = dest_q;
    rf_wdata   = data_q;
    hz_valid   = (state != IDLE);
    hz_data_ok = (state == WRITE);
    hz_reg     = hz_valid ? dest_q : '0;
    hz_data    = hz_valid ? data_q : '0;
  end

endmodule
